prio_arbiter_rr: RTL and testbench
==================================

// Module: prio_arbiter_rr
// PURPOSE
//   Parametrised, registered priority encoder / arbiter over N request lines.
//   Selects one asserted request per decision in fixed (LSB-first) or round-robin
//   mode; presents index + one-hot grant on a valid/ready output; flags the
//   all-zero request vector. Sits between request sources and a downstream consumer.
// PARAMETERS
//   N      8                  number of request lines (N >= 1)
//   IDX_W  (N>1)?$clog2(N):1  width of the index output
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   req        in   N      request vector; bit i = request i; must be 0/1, never X/Z
//   mode       in   1      0 = fixed priority (bit 0 highest), 1 = round-robin
//   out_ready  in   1      consumer accepts current grant
//   out_valid  out  1      grant/idx valid
//   idx        out  IDX_W  index of the granted request
//   grant      out  N      one-hot grant, equals 1 << idx while out_valid, else 0
//   invalid    out  1      registered: req was all-zero in the previous cycle
// BEHAVIOUR
//   - Reset: out_valid=0, idx=0, grant=0, invalid=0, state=IDLE, rr_ptr=N-1.
//   - FSM: IDLE, HOLD.
//     IDLE: req!=0 -> register winner into idx/grant, out_valid<=1, go to HOLD.
//           req==0 -> stay IDLE.
//     HOLD: idx/grant/out_valid stable while out_ready=0; req changes are ignored.
//           out_valid&&out_ready: rr_ptr<=idx; if req!=0 in the same cycle, register
//           new winner (computed with rr_ptr=idx), stay HOLD (back-to-back, 1/cycle);
//           else out_valid<=0, grant<=0, go to IDLE.
//   - Latency: req to out_valid = 1 cycle. Throughput: 1 grant/cycle with out_ready=1.
//   - Winner: mode=0 -> lowest set bit of req. mode=1 -> lowest set bit at index
//     > rr_ptr; none -> wrap to lowest set bit overall. rr_ptr=N-1 means search from 0.
//   - mode sampled only at a decision; changing mode in HOLD has no effect on idx.
//   - rr_ptr updates only on a handshake, in both modes.
//   - invalid <= (req==0) every cycle, independent of state.
//   - N=1: idx always 0; grant=out_valid.
//   - Reset mid-HOLD: pending grant dropped, out_valid=0 next cycle, rr_ptr=N-1.
// CONFIGURATION
//   PRIO_ERR_CNT_EN defined: adds port err_cnt out 16 - counts cycles with
//     invalid=1, saturating at 16'hFFFF; reset to 0 by rst.
//   Not defined: err_cnt port and counter absent; all other behaviour identical.
// STRUCTURE
//   Shared package prio_pkg: state encoding (IDLE=1'b0, HOLD=1'b1), ERR_CNT_W=16,
//     ERR_CNT_MAX constant.
//   Sub-module prio_find_first: combinational find-first-set over N bits starting
//     after a given index, with wrap; outputs index + found. Instantiated once;
//     fixed mode drives start index N-1.
// TESTING
//   1. rst=1 two cycles with req=8'hFF -> out_valid=0, idx=0, grant=0, invalid=0.
//   2. mode=0, req=8'b1010_0100, out_ready=1 -> one cycle later idx=2, grant=8'h04;
//      three handshakes give idx=2,2,2.
//   3. mode=1, req=8'b1010_0100, out_ready=1 -> idx sequence 2,5,7,2 (wrap).
//   4. mode=0, req=8'h04, out_ready=0 four cycles, req changes to 8'h01 -> idx=2,
//      grant=8'h04 held; out_ready=1 -> next idx=0, grant=8'h01.
//   5. req=0 after a grant with out_ready=1 -> invalid=1 next cycle, out_valid=0
//      after handshake; PRIO_ERR_CNT_EN: err_cnt +1/cycle, preloaded near max
//      saturates at 16'hFFFF.
//   6. mode=1, handshake at idx=5, then rst=1 in HOLD -> out_valid=0; after
//      release req=8'b1010_0100 -> idx=2 (rr_ptr reset to N-1).

Source files
------------

// File: rtl/prio_arbiter_rr_pkg.sv
// ============================================================================
// Module  : prio_pkg
// Brief   : Shared state encoding and error-counter constants for prio_arbiter_rr.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package prio_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int                   ERR_CNT_W   = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/prio_arbiter_rr_if.sv
// ============================================================================
// Module  : prio_arbiter_rr_if
// Brief   : Request/grant bundle; err_cnt exists only with PRIO_ERR_CNT_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface prio_arbiter_rr_if #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
);
    import prio_pkg::*;

    logic [N-1:0]     req;
    logic             mode;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     grant;
    logic             invalid;
`ifdef PRIO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (input req, mode, out_ready,
                    output out_valid, idx, grant, invalid, err_cnt);
    modport slave  (output req, mode, out_ready,
                    input out_valid, idx, grant, invalid, err_cnt);
`else
    modport master (input req, mode, out_ready,
                    output out_valid, idx, grant, invalid);
    modport slave  (output req, mode, out_ready,
                    input out_valid, idx, grant, invalid);
`endif

endinterface

`default_nettype wire

// File: rtl/prio_arbiter_rr_find_first.sv
// ============================================================================
// Module  : prio_find_first
// Brief   : Combinational find-first-set strictly after start_i, wrapping to 0.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module prio_find_first #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     req_i,
    input  wire logic [IDX_W-1:0] start_i,
    output logic      [IDX_W-1:0] idx_o,
    output logic                  found_o
);

    int pos;

    // Offsets 1..N cover every bit once; offset N lands back on start_i itself.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(start_i) + k) % N;
            if (!found_o && req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prio_arbiter_rr.sv
// ============================================================================
// Module  : prio_arbiter_rr
// Brief   : Registered fixed/round-robin arbiter with valid/ready grant output.
//           Define PRIO_ERR_CNT_EN to add the saturating invalid-cycle counter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module prio_arbiter_rr
    import prio_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    prio_arbiter_rr_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e           state_q;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic [N-1:0]     grant_q;
    logic             invalid_q;
    logic [IDX_W-1:0] rr_ptr_q;

    logic [IDX_W-1:0] start_d;
    logic [IDX_W-1:0] win_idx_d;
    logic             win_found_d;
    logic [N-1:0]     win_grant_d;

    // A decision in HOLD happens on a handshake, where rr_ptr is about to become idx.
    always_comb begin
        start_d = LAST_IDX;
        if (bus.mode)
            start_d = (state_q == HOLD) ? idx_q : rr_ptr_q;
    end

    prio_find_first #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_find_first (
        .req_i   (bus.req),
        .start_i (start_d),
        .idx_o   (win_idx_d),
        .found_o (win_found_d)
    );

    assign win_grant_d = N'(1) << win_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            grant_q   <= '0;
            invalid_q <= 1'b0;
            rr_ptr_q  <= LAST_IDX;
        end else begin
            invalid_q <= ~|bus.req;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        idx_q   <= win_idx_d;
                        grant_q <= win_grant_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        rr_ptr_q <= idx_q;
                        if (win_found_d) begin
                            idx_q   <= win_idx_d;
                            grant_q <= win_grant_d;
                        end else begin
                            valid_q <= 1'b0;
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.idx       = idx_q;
    assign bus.grant     = grant_q;
    assign bus.invalid   = invalid_q;

`ifdef PRIO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (invalid_q && (err_cnt_q != ERR_CNT_MAX))
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end

    assign bus.err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prio_arbiter_rr.sv
// ============================================================================
// Module  : tb_prio_arbiter_rr
// Brief   : Scenario-driven scoreboard bench for prio_arbiter_rr (N=8).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_prio_arbiter_rr;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    prio_arbiter_rr_if #(.N(8)) bus ();

    prio_arbiter_rr #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 8'hFF;
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.idx !== 3'd0 || bus.grant !== 8'h00 ||
                bus.invalid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset: valid=%b idx=%0d grant=%h invalid=%b, expected 0/0/00/0",
                         bus.out_valid, bus.idx, bus.grant, bus.invalid);
            end
        end
        rst = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_fixed();
        int exp_q[$];
        int e;
        int c;
        logic [7:0] g;
        exp_q = '{2, 2, 2};
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        bus.req = 8'b1010_0100;
        c = 0;
        while (exp_q.size() > 0 && c < 20) begin
            tick();
            c++;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                g = 8'h01 << e;
                vectors++;
                if (bus.idx !== 3'(e) || bus.grant !== g || (exp_q.size() == 2 && c != 1)) begin
                    miscompares++;
                    $display("FAIL fixed_grant: idx=%0d grant=%h cycle=%0d, expected idx=%0d grant=%h",
                             bus.idx, bus.grant, c, e, g);
                end
                if (exp_q.size() == 0) bus.req = '0;
            end
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL fixed_timeout: %0d grants outstanding, expected 0", exp_q.size());
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.grant !== 8'h00) begin
            miscompares++;
            $display("FAIL fixed_drop: valid=%b grant=%h, expected 0/00", bus.out_valid, bus.grant);
        end
    endtask

    task automatic test_rr();
        int exp_q[$];
        int e;
        int c;
        logic [7:0] g;
        do_reset();
        exp_q = '{2, 5, 7, 2};
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        bus.req = 8'b1010_0100;
        c = 0;
        while (exp_q.size() > 0 && c < 20) begin
            tick();
            c++;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                g = 8'h01 << e;
                vectors++;
                if (bus.idx !== 3'(e) || bus.grant !== g) begin
                    miscompares++;
                    $display("FAIL rr_grant: idx=%0d grant=%h, expected idx=%0d grant=%h",
                             bus.idx, bus.grant, e, g);
                end
                if (exp_q.size() == 0) bus.req = '0;
            end
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rr_timeout: %0d grants outstanding, expected 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_hold();
        int exp_q[$];
        int e;
        int c;
        logic [7:0] g;
        bus.mode = 1'b0;
        bus.out_ready = 1'b0;
        bus.req = 8'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.idx !== 3'd2 || bus.grant !== 8'h04) begin
                miscompares++;
                $display("FAIL hold_stable: valid=%b idx=%0d grant=%h, expected 1/2/04",
                         bus.out_valid, bus.idx, bus.grant);
            end
            if (i == 0) begin
                bus.req = 8'h01;
                bus.mode = 1'b1;
            end
        end
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        exp_q = '{2, 0};
        c = 0;
        while (exp_q.size() > 0 && c < 10) begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                e = exp_q.pop_front();
                g = 8'h01 << e;
                vectors++;
                if (bus.idx !== 3'(e) || bus.grant !== g) begin
                    miscompares++;
                    $display("FAIL hold_release: idx=%0d grant=%h, expected idx=%0d grant=%h",
                             bus.idx, bus.grant, e, g);
                end
                if (exp_q.size() == 0) bus.req = '0;
            end
            tick();
            c++;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL hold_timeout: %0d grants outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_invalid();
`ifdef PRIO_ERR_CNT_EN
        logic [15:0] e0;
        int c;
`endif
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        bus.req = 8'h04;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.invalid !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_clear: valid=%b invalid=%b, expected 1/0", bus.out_valid, bus.invalid);
        end
        bus.req = '0;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.grant !== 8'h00 || bus.invalid !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_set: valid=%b grant=%h invalid=%b, expected 0/00/1",
                     bus.out_valid, bus.grant, bus.invalid);
        end
`ifdef PRIO_ERR_CNT_EN
        e0 = bus.err_cnt;
        tick();
        vectors++;
        if (bus.err_cnt !== e0 + 16'd1) begin
            miscompares++;
            $display("FAIL err_cnt_inc: err_cnt=%h, expected %h", bus.err_cnt, e0 + 16'd1);
        end
        c = 0;
        while (bus.err_cnt !== 16'hFFFF && c < 70000) begin
            tick();
            c++;
        end
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (bus.err_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL err_cnt_sat: err_cnt=%h, expected ffff", bus.err_cnt);
        end
`endif
    endtask

    task automatic test_reset_hold();
        int exp_q[$];
        int e;
        int c;
        do_reset();
        exp_q = '{2, 5, 7};
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        bus.req = 8'b1010_0100;
        c = 0;
        while (exp_q.size() > 0 && c < 10) begin
            tick();
            c++;
            if (bus.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.idx !== 3'(e)) begin
                    miscompares++;
                    $display("FAIL rsthold_seq: idx=%0d, expected %0d", bus.idx, e);
                end
            end
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rsthold_timeout: %0d grants outstanding, expected 0", exp_q.size());
        end
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.grant !== 8'h00 || bus.idx !== 3'd0) begin
            miscompares++;
            $display("FAIL rsthold_drop: valid=%b idx=%0d grant=%h, expected 0/0/00",
                     bus.out_valid, bus.idx, bus.grant);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.idx !== 3'd2 || bus.grant !== 8'h04) begin
            miscompares++;
            $display("FAIL rsthold_ptr: valid=%b idx=%0d grant=%h, expected 1/2/04",
                     bus.out_valid, bus.idx, bus.grant);
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_rr();
        test_hold();
        test_invalid();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
